// File: rtl/dump_sequencer_pkg.sv
// Shared tracking-engine definitions: state dump offsets and the dump sequencer FSM states.
package dump_sequencer_pkg;

    localparam logic [4:0] OFF_FIRST      = 5'd6;
    localparam logic [4:0] OFF_SKIP       = 5'd14;
    localparam logic [4:0] OFF_LAST_FIXED = 5'd15;
    localparam logic [4:0] OFF_ACC_BASE   = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } dump_state_e;

    // Offset following `off` in the dump walk; offset 14 is hopped over.
    function automatic logic [4:0] next_offset(input logic [4:0] off);
        return (off == OFF_SKIP - 5'd1) ? OFF_LAST_FIXED : off + 5'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// 4-way round-robin picker; the pointer remembers the last channel served.
module rr_arbiter4 (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [3:0] req,
    input  logic       sel_en,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] ptr_q;
    logic [1:0] cand;

    // Walk from farthest to nearest so the channel right after the pointer wins.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k + 1);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q <= 2'd3;
        end else if (sel_en && valid) begin
            ptr_q <= idx;
        end
    end

endmodule

// File: rtl/dump_sequencer.sv
// Copies every dump word of one physical correlator into the logical-channel state RAM,
// serving pending dump requests round-robin and absorbing RAM back-pressure with a skid.
module dump_sequencer
    import dump_sequencer_pkg::*;
#(
    parameter int unsigned ACC_WORDS = 8,
    parameter int unsigned LCH_W     = 5
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [3:0]       dump_req,
    input  logic [LCH_W-1:0] logic_ch_0,
    input  logic [LCH_W-1:0] logic_ch_1,
    input  logic [LCH_W-1:0] logic_ch_2,
    input  logic [LCH_W-1:0] logic_ch_3,
    output logic [1:0]       physical_channel_index,
    output logic [4:0]       state_addr,
    input  logic [31:0]      state_d4wt,
    output logic             ram_req,
    input  logic             ram_gnt,
    output logic [LCH_W+4:0] ram_addr,
    output logic [31:0]      ram_d4wt,
    output logic [3:0]       dump_done,
    output logic             busy
);

    localparam logic [4:0] LAST_OFF = OFF_ACC_BASE + 5'(ACC_WORDS - 1);

    dump_state_e      state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [LCH_W-1:0] lch_q, lch_d;
    logic [4:0]       state_addr_q, state_addr_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       done_q, done_d;
    logic             infl_v_q, infl_v_d;
    logic [4:0]       infl_off_q, infl_off_d;
    logic             skid_v_q;
    logic [4:0]       skid_off_q;
    logic [31:0]      skid_data_q;
    logic             out_v_q;
    logic [4:0]       out_off_q;
    logic [31:0]      out_data_q;

    logic             stall;
    logic             sel;
    logic             arb_valid;
    logic [1:0]       arb_idx;
    logic [LCH_W-1:0] lch_sel;

    assign stall = out_v_q & ~ram_gnt;

    rr_arbiter4 u_arb (
        .clk    (clk),
        .rst_b  (rst_b),
        .req    (pending_q),
        .sel_en (sel),
        .valid  (arb_valid),
        .idx    (arb_idx)
    );

    always_comb begin
        lch_sel = logic_ch_0;
        unique case (arb_idx)
            2'd0: lch_sel = logic_ch_0;
            2'd1: lch_sel = logic_ch_1;
            2'd2: lch_sel = logic_ch_2;
            2'd3: lch_sel = logic_ch_3;
            default: lch_sel = logic_ch_0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        lch_d        = lch_q;
        state_addr_d = state_addr_q;
        infl_v_d     = 1'b0;
        infl_off_d   = infl_off_q;
        done_d       = 4'b0000;
        sel          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    sel          = 1'b1;
                    ch_d         = arb_idx;
                    lch_d        = lch_sel;
                    state_addr_d = OFF_FIRST;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // A stalled output keeps the mux re-reading the same offset; nothing is tracked.
                if (!stall) begin
                    infl_v_d   = 1'b1;
                    infl_off_d = state_addr_q;
                    if (state_addr_q == LAST_OFF) begin
                        state_addr_d = 5'd0;
                        state_d      = DRAIN;
                    end else begin
                        state_addr_d = next_offset(state_addr_q);
                    end
                end
            end
            DRAIN: begin
                if (!infl_v_q && !skid_v_q && (!out_v_q || ram_gnt)) begin
                    done_d  = 4'b0001 << ch_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // New requests win over the clear of the channel being selected.
    assign pending_d = (pending_q & ~(sel ? (4'b0001 << arb_idx) : 4'b0000)) | dump_req;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            ch_q         <= 2'd0;
            lch_q        <= '0;
            state_addr_q <= 5'd0;
            pending_q    <= 4'b0000;
            done_q       <= 4'b0000;
            infl_v_q     <= 1'b0;
            infl_off_q   <= 5'd0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            lch_q        <= lch_d;
            state_addr_q <= state_addr_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            infl_v_q     <= infl_v_d;
            infl_off_q   <= infl_off_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            skid_v_q    <= 1'b0;
            skid_off_q  <= 5'd0;
            skid_data_q <= 32'd0;
            out_v_q     <= 1'b0;
            out_off_q   <= 5'd0;
            out_data_q  <= 32'd0;
        end else if (!stall) begin
            if (skid_v_q) begin
                out_v_q     <= 1'b1;
                out_off_q   <= skid_off_q;
                out_data_q  <= skid_data_q;
                skid_v_q    <= infl_v_q;
                skid_off_q  <= infl_off_q;
                skid_data_q <= state_d4wt;
            end else begin
                out_v_q    <= infl_v_q;
                out_off_q  <= infl_off_q;
                out_data_q <= state_d4wt;
            end
        end else if (infl_v_q) begin
            skid_v_q    <= 1'b1;
            skid_off_q  <= infl_off_q;
            skid_data_q <= state_d4wt;
        end
    end

    assign physical_channel_index = ch_q;
    assign state_addr             = state_addr_q;
    assign ram_req                = out_v_q;
    assign ram_addr               = {lch_q, out_off_q};
    assign ram_d4wt               = out_data_q;
    assign dump_done              = done_q;
    assign busy                   = (state_q != IDLE);

endmodule

// File: doc/dump_sequencer.md
# dump_sequencer

Walks the per-channel state dump interface of the tracking engine and copies every dump word of one physical correlator into the logical-channel state RAM. Sits downstream of the state multiplexer: it drives `physical_channel_index`/`state_addr`, consumes the registered `state_d4wt` one cycle later, and arbitrates for the state RAM write port with a req/gnt handshake. Pending dump requests from the 4 physical correlators are served in round-robin order.

## Interface
- `ACC_WORDS`, 8: number of I/Q accumulator words at state addresses 16..16+ACC_WORDS-1 (1..16).
- `LCH_W`, 5: logical channel number width; RAM address width is LCH_W+5.
- `clk`  in  1  system clock.
- `rst_b`  in  1  asynchronous reset, active-low.
- `dump_req`  in  4  per-physical-channel one-cycle dump request.
- `logic_ch_0..logic_ch_3`  in  LCH_W  logical channel bound to each physical channel.
- `physical_channel_index`  out  2  selects the correlator being dumped.
- `state_addr`  out  5  dump word offset presented to the state mux.
- `state_d4wt`  in  32  registered dump word for the previous cycle's `state_addr`.
- `ram_req`  out  1  write request; `ram_addr`/`ram_d4wt` valid while high.
- `ram_gnt`  in  1  write accepted on a clock edge where `ram_req` and `ram_gnt` are both high.
- `ram_addr`  out  LCH_W+5  {logical channel, offset}.
- `ram_d4wt`  out  32  write data.
- `dump_done`  out  4  one-cycle pulse when a channel's dump is fully written.
- `busy`  out  1  high while the FSM is not IDLE.

## Operation
- Reset values: all outputs 0, and the pending register, skid, round-robin pointer and FSM are cleared.
- Word sequence per dump, with N = 9 + ACC_WORDS: offsets 6, 7, 8, 9, 10, 11, 12, 13, 15, then 16..15+ACC_WORDS. Offsets 0..5 and 14 are never issued.
- `pending[3:0]` is set by `dump_req`. A set bit clears when its channel is selected.
  - A request for an already-pending channel merges into that pending bit.
  - A request for the channel currently being dumped sets its pending bit again, so the channel is dumped a second time afterwards.
- Round-robin selection: the search starts at the channel after the last served one. The pointer resets to 3, so channel 0 wins first.
- FSM states:
  - IDLE: when any pending bit is set, select a channel, latch its `logic_ch`, drive `physical_channel_index`, set `state_addr` to 6, and go to ISSUE.
  - ISSUE: `state_addr` advances one offset per cycle unless stalled. After the last offset is issued, `state_addr` goes to 0 and the FSM moves to DRAIN.
  - DRAIN: wait until the in-flight word, the skid and the output register are all written. Then pulse `dump_done[ch]` and return to IDLE.
- Pipeline: issue (`state_addr`) → external mux register → output register (`ram_*`).
- Stall: when `ram_req` is high and `ram_gnt` is low, the output register holds its value and issue freezes. The word already in flight from the mux is captured into a one-entry skid register. When the stall clears, the skid empties into the output register before issue resumes. No word is ever lost or duplicated.
- `physical_channel_index` stays constant from selection until DRAIN exits.
- A `ram_gnt` that arrives while `ram_req` is low is ignored.

## Timing
- With `dump_req` sampled at edge E0: `busy` and `state_addr`=6 appear after E1, and `ram_req` rises after E3 with offset 6.
- With `ram_gnt` held high, the N writes are accepted on consecutive edges. `dump_done` pulses in the cycle after the last accepted write.
- Back-to-back dumps: at least one IDLE cycle separates `dump_done` and the next `state_addr`=6.
- Each stall cycle adds exactly one cycle to the total dump time.
- `rst_b` asserted mid-dump aborts immediately: pending bits are lost and no `dump_done` is issued.

## Structure
- Shared tracking-engine package holds:
  - the dump offset constants (first offset 6, skipped offset 14, last fixed offset 15, accumulator base 16);
  - the FSM state enum {IDLE, ISSUE, DRAIN}.
- One sub-module: `rr_arbiter4` (4-way round-robin pick with pointer update on select).
- The skid and output register stay inline.

## Test plan
- Single dump: `dump_req`=0001, `logic_ch_0`=5, `ram_gnt`=1 → 17 writes to addresses 5·32+{6..13, 15, 16..23} carrying the injected words; `dump_done`=0001 20 cycles after E0.
- Stall: `ram_gnt` low for 3 cycles while the word for offset 9 is presented → write order unchanged, no duplicates, `dump_done` 3 cycles later than the single-dump case.
- Simultaneous `dump_req`=1010 after reset → channel 1 dumped fully, then channel 3; pointer ends at 3, so a following `dump_req`=1001 serves channel 0 first.
- Re-request: `dump_req`=0100 issued during the channel 2 dump → two `dump_done[2]` pulses, 34 writes in total.
- Reset during ISSUE at offset 11 → all outputs 0 the next cycle; no `dump_done`; a fresh request then dumps normally from offset 6.
- `ACC_WORDS`=1 → exactly 10 writes, with the last at offset 16.
